// File: rtl/contador_universal.sv
// Universal up/down counter with programmable terminal value, wrap or saturate
// at the limits, synchronous clear/load and a registered limit-event pulse.
module contador_universal #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MAX   = 9
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             up_down,
    input  logic             sat_mode,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] salida,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("contador_universal: WIDTH must be in 2..32");
        end
        if (MAX < 1 || (WIDTH < 32 && MAX > (32'd1 << WIDTH) - 32'd1)) begin : g_bad_max
            $error("contador_universal: MAX must be in 1..2^WIDTH-1");
        end
    endgenerate

    logic [WIDTH-1:0] salida_q, salida_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] limit;
    logic             at_limit;
    logic [WIDTH-1:0] din_clamped;
    logic [WIDTH-1:0] count_next;

    assign limit       = up_down ? MAX_V : '0;
    assign at_limit    = (salida_q == limit);
    assign din_clamped = (din > MAX_V) ? MAX_V : din;

    // At the limit the counter either stays put (saturate) or jumps to the
    // opposite end of the range, which is not the natural overflow unless MAX is all-ones.
    always_comb begin
        count_next = salida_q;
        if (at_limit) begin
            if (sat_mode)
                count_next = salida_q;
            else
                count_next = up_down ? '0 : MAX_V;
        end else if (up_down) begin
            count_next = salida_q + WIDTH'(1);
        end else begin
            count_next = salida_q - WIDTH'(1);
        end
    end

    always_comb begin
        salida_d = salida_q;
        wrap_d   = 1'b0;
        if (clear) begin
            salida_d = '0;
        end else if (load) begin
            salida_d = din_clamped;
        end else if (enable) begin
            salida_d = count_next;
            wrap_d   = at_limit;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            salida_q <= '0;
            wrap_q   <= 1'b0;
        end else begin
            salida_q <= salida_d;
            wrap_q   <= wrap_d;
        end
    end

    assign salida = salida_q;
    assign wrap   = wrap_q;
    assign tc     = at_limit;

endmodule

// File: doc/contador_universal.md
CONTADOR_UNIVERSAL -- requirements
Module: contador_universal

Interface
REQ-001 Parameter WIDTH, default 4: counter width in bits; legal range 2..32.
REQ-002 Parameter MAX, default 9: terminal value; count range 0..MAX inclusive; legal range 1..2^WIDTH-1.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  count enable; when low, count holds.
REQ-006 up_down  input  1  direction: 1 = count up, 0 = count down.
REQ-007 sat_mode  input  1  limit mode: 0 = wrap-around, 1 = saturate at limits.
REQ-008 clear  input  1  synchronous clear to 0.
REQ-009 load  input  1  synchronous parallel load of din.
REQ-010 din  input  WIDTH  parallel load value.
REQ-011 salida  output  WIDTH  current count (registered).
REQ-012 tc  output  1  terminal count (combinational): salida == limit for the current direction.
REQ-013 wrap  output  1  registered one-cycle pulse flagging a limit event in the previous cycle.

Function
REQ-014 Limit: MAX when up_down = 1; 0 when up_down = 0.
REQ-015 Priority per rising edge: clear > load > enable count > hold.
REQ-016 clear = 1: salida <= 0 next edge, regardless of load/enable.
REQ-017 load = 1, clear = 0: salida <= din if din <= MAX, else MAX (clamped).
REQ-018 enable = 1, up_down = 1, salida < MAX: salida <= salida + 1.
REQ-019 enable = 1, up_down = 0, salida > 0: salida <= salida - 1.
REQ-020 enable = 1, at limit, sat_mode = 0: up goes MAX -> 0; down goes 0 -> MAX.
REQ-021 enable = 1, at limit, sat_mode = 1: salida holds at limit.
REQ-022 Limit event: enable = 1, clear = 0, load = 0, and salida at limit on a rising edge; applies in both modes.
REQ-023 wrap = 1 for exactly the cycle after each limit event; otherwise 0.
REQ-024 Consecutive limit events (saturate mode held at limit) produce wrap high on every such cycle.
REQ-025 tc = 1 whenever salida equals the current limit, independent of enable.
REQ-026 Changing up_down or sat_mode takes effect on the next edge; no internal state beyond salida and wrap.
REQ-027 Arithmetic is performed at WIDTH bits; salida never exceeds MAX.
REQ-028 When MAX = 2^WIDTH-1, natural binary overflow coincides with REQ-020.

Reset
REQ-029 reset = 1 forces salida = 0 and wrap = 0 immediately, without waiting for a clock edge.
REQ-030 While reset = 1, all other inputs are ignored; tc reflects salida = 0 (tc = 1 if up_down = 0).
REQ-031 First active edge after reset deasserts applies normal priority rules.
REQ-032 For simulation, salida and wrap initialise to 0.

Verification (WIDTH = 4, MAX = 9)
REQ-033 Up/wrap: reset, then enable = 1, up_down = 1, sat_mode = 0 for 11 edges -> salida = 1..9, 0, 1; tc = 1 while salida = 9; wrap = 1 only in the cycle after 9 -> 0.
REQ-034 Down/wrap: from salida = 0, up_down = 0, enable = 1 for 2 edges -> 9, then 8; tc = 1 at 0; wrap pulse after 0 -> 9.
REQ-035 Saturate: sat_mode = 1, up, count to 9 and hold enable for 3 more edges -> salida stays 9; wrap = 1 on each of the 3 following cycles.
REQ-036 Load/clamp: load = 1, din = 12 -> salida = 9; load = 1, din = 5 -> 5; clear = 1 and load = 1 with din = 7 -> 0.
REQ-037 Async reset mid-count: at salida = 6, assert reset between edges -> salida = 0 and wrap = 0 before the next rising edge; deassert -> counting resumes from 0.
REQ-038 Hold: enable = 0 for 4 edges at salida = 3 -> salida stays 3, wrap = 0.
